// File: rtl/dsp_sample_fifo.sv
// Sample FIFO: circular buffer with first-word-fall-through head, sticky overflow/underflow flags, level interrupt.
// Latency: a pushed sample is visible on sample_out one cycle after the push edge; status outputs are combinational from count.
// Backpressure: none toward the source; a push into a full FIFO with no same-cycle pop is dropped and flagged as overflow.
module dsp_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             pop,
    input  logic             flush,
    input  logic             clear_flags,
    input  logic [CW-1:0]    threshold,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic             level_irq
);

    logic [1:0]       r_rst_sync;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_run;
    logic w_push_req;
    logic w_pop_req;
    logic w_pop_acc;
    logic w_push_acc;
    logic w_ovf_evt;
    logic w_udf_evt;

    // Two-flop release of the asynchronous reset; no state moves until it has propagated.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

    // Flush swallows any same-cycle push/pop so they neither move state nor raise flags.
    assign w_push_req = in_valid & w_run & ~flush;
    assign w_pop_req  = pop & w_run & ~flush;
    assign w_pop_acc  = w_pop_req & (r_count != '0);
    assign w_push_acc = w_push_req & ((r_count < CW'(DEPTH)) | w_pop_acc);
    assign w_ovf_evt  = w_push_req & ~w_push_acc;
    assign w_udf_evt  = w_pop_req & (r_count == '0);

    // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_run && flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky error flags; a new event in the same cycle as clear_flags keeps the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_run) begin
            r_overflow  <= (r_overflow  & ~clear_flags) | w_ovf_evt;
            r_underflow <= (r_underflow & ~clear_flags) | w_udf_evt;
        end
    end

    // Sample storage is deliberately not reset; the empty gate on sample_out hides stale entries.
    always_ff @(posedge clock) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Head-of-queue view and status decode, all from the registered count.
    always_comb begin
        sample_out   = '0;
        if (r_count != '0) begin
            sample_out = r_mem[r_rd_ptr];
        end
        sample_valid = (r_count != '0);
        empty        = (r_count == '0);
        full         = (r_count == CW'(DEPTH));
        level_irq    = (threshold != '0) && (r_count >= threshold);
    end

    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_dsp_sample_fifo.sv
module tb_dsp_sample_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int CW    = 4;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             pop;
    logic             flush;
    logic             clear_flags;
    logic [CW-1:0]    threshold;
    logic [WIDTH-1:0] sample_out;
    logic             sample_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
    logic             level_irq;

    int checks   = 0;
    int failures = 0;

    dsp_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .pop         (pop),
        .flush       (flush),
        .clear_flags (clear_flags),
        .threshold   (threshold),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .underflow   (underflow),
        .level_irq   (level_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply the currently driven inputs at the next rising edge, then return strobes to idle.
    task automatic step();
        @(posedge clock);
        #1;
        in_valid    = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    task automatic do_flush_clear();
        flush       = 1'b1;
        clear_flags = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 0; in_data = 0; pop = 0; flush = 0; clear_flags = 0; threshold = 0;
        #12;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || sample_valid !== 1'b0) begin failures++; $display("FAIL reset_status empty=%b full=%b valid=%b exp=1,0,0", empty, full, sample_valid); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || level_irq !== 1'b0) begin failures++; $display("FAIL reset_flags ovf=%b udf=%b irq=%b exp=0,0,0", overflow, underflow, level_irq); end
        checks++; if (sample_out !== 32'h0) begin failures++; $display("FAIL reset_sample got=%h exp=0", sample_out); end
        @(negedge clock);
        reset = 1'b1;
        // Push on the first edge after release must be ignored by the synchronizer.
        push(32'hDEAD);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL release_first_edge count got=%0d exp=0", count); end
        step();
        step();
    endtask

    task automatic test_basic();
        push(32'h11); push(32'h22); push(32'h33);
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
        checks++; if (sample_out !== 32'h11) begin failures++; $display("FAIL basic_head got=%h exp=11", sample_out); end
        pop = 1'b1; step();
        checks++; if (sample_out !== 32'h22) begin failures++; $display("FAIL basic_after_pop got=%h exp=22", sample_out); end
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL basic_count_pop got=%0d exp=2", count); end
        do_flush_clear();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) push(32'(i));
        checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL ovf_full full=%b count=%0d exp=1,8", full, count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (sample_out !== 32'(i)) begin failures++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, sample_out, 32'(i)); end
            pop = 1'b1; step();
        end
        checks++; if (empty !== 1'b1 || sample_out !== 32'h0) begin failures++; $display("FAIL ovf_drained empty=%b out=%h exp=1,0", empty, sample_out); end
        clear_flags = 1'b1; step();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_pushpop();
        for (int i = 1; i <= 8; i++) push(32'(i));
        in_valid = 1'b1; in_data = 32'hAA; pop = 1'b1; step();
        checks++; if (count !== 4'd8 || overflow !== 1'b0) begin failures++; $display("FAIL fullpp count=%0d ovf=%b exp=8,0", count, overflow); end
        checks++; if (sample_out !== 32'h2) begin failures++; $display("FAIL fullpp_head got=%h exp=2", sample_out); end
        for (int i = 1; i <= 7; i++) begin pop = 1'b1; step(); end
        checks++; if (sample_out !== 32'hAA || count !== 4'd1) begin failures++; $display("FAIL fullpp_last out=%h count=%0d exp=aa,1", sample_out, count); end
        do_flush_clear();
    endtask

    task automatic test_empty_pushpop();
        in_valid = 1'b1; in_data = 32'h5; pop = 1'b1; step();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL emptypp_udf got=%b exp=1", underflow); end
        checks++; if (count !== 4'd1 || sample_out !== 32'h5) begin failures++; $display("FAIL emptypp_data count=%0d out=%h exp=1,5", count, sample_out); end
        clear_flags = 1'b1; step();
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL emptypp_clear got=%b exp=0", underflow); end
        do_flush_clear();
    endtask

    task automatic test_clear_set_wins();
        pop = 1'b1; step();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL setwins_pre got=%b exp=1", underflow); end
        pop = 1'b1; clear_flags = 1'b1; step();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL setwins got=%b exp=1", underflow); end
    endtask

    task automatic test_threshold();
        threshold = 4'd4;
        push(32'hA1); push(32'hA2); push(32'hA3);
        checks++; if (level_irq !== 1'b0) begin failures++; $display("FAIL thr_below got=%b exp=0", level_irq); end
        push(32'hA4);
        checks++; if (level_irq !== 1'b1) begin failures++; $display("FAIL thr_at got=%b exp=1", level_irq); end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hFF; pop = 1'b1; step();
        checks++; if (count !== 4'd0 || level_irq !== 1'b0) begin failures++; $display("FAIL thr_flush count=%0d irq=%b exp=0,0", count, level_irq); end
        checks++; if (underflow !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL thr_flags udf=%b ovf=%b exp=1,0", underflow, overflow); end
        threshold = 4'd0;
        for (int i = 0; i < 8; i++) push(32'(i));
        checks++; if (level_irq !== 1'b0) begin failures++; $display("FAIL thr_disabled got=%b exp=0", level_irq); end
        do_flush_clear();
    endtask

    task automatic test_midreset();
        for (int i = 1; i <= 9; i++) push(32'(i + 16));
        for (int i = 0; i < 3; i++) begin pop = 1'b1; step(); end
        checks++; if (count !== 4'd5 || overflow !== 1'b1) begin failures++; $display("FAIL mid_pre count=%0d ovf=%b exp=5,1", count, overflow); end
        reset = 1'b0;
        #2;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL mid_async count=%0d empty=%b full=%b exp=0,1,0", count, empty, full); end
        checks++; if (overflow !== 1'b0 || sample_out !== 32'h0 || sample_valid !== 1'b0) begin failures++; $display("FAIL mid_async_out ovf=%b out=%h valid=%b exp=0,0,0", overflow, sample_out, sample_valid); end
        reset = 1'b1;
        step(); step();
        push(32'h77);
        checks++; if (count !== 4'd1 || sample_out !== 32'h77) begin failures++; $display("FAIL mid_after count=%0d out=%h exp=1,77", count, sample_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_empty_pushpop();
        test_clear_set_wins();
        test_threshold();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_sample_fifo.md
DSP_SAMPLE_FIFO -- requirements
Module: dsp_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 8, sample storage entries; power of two, range 2..64.
REQ-002 Parameter WIDTH, default 32, sample width in bits; matches the dsp_unit sample_in width.
REQ-003 Port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; this is the only reset.
REQ-005 Port in_valid  input  1  one-cycle push strobe from the sample source; no backpressure.
REQ-006 Port in_data  input  WIDTH  sample captured when in_valid=1.
REQ-007 Port pop  input  1  one-cycle read strobe from the consumer (CPU/DSP side).
REQ-008 Port flush  input  1  synchronous discard of all stored samples.
REQ-009 Port clear_flags  input  1  synchronous clear of the sticky overflow/underflow flags.
REQ-010 Port threshold  input  log2(DEPTH)+1  level for the level_irq output; 0 disables it.
REQ-011 Port sample_out  output  WIDTH  head-of-queue sample, first-word-fall-through.
REQ-012 Port sample_valid  output  1  high when count>0.
REQ-013 Port count  output  log2(DEPTH)+1  number of stored samples, 0..DEPTH.
REQ-014 Port full / empty  output  1 each  count==DEPTH / count==0.
REQ-015 Port overflow / underflow  output  1 each  sticky error flags.
REQ-016 Port level_irq  output  1  high when threshold!=0 and count>=threshold.

Function
REQ-017 Storage: circular buffer with write pointer, read pointer and count register; the pointers wrap from DEPTH-1 to 0.
REQ-018 Push accepted when in_valid=1 and (count<DEPTH or pop is accepted in the same cycle); the sample is written at the write pointer, which then advances.
REQ-019 Push while full with no accepted pop: sample dropped; pointers and count unchanged; overflow set on the next edge.
REQ-020 Pop accepted when pop=1 and count>0; the read pointer advances; sample_out shows the next entry in the cycle after the edge.
REQ-021 Pop while empty: no state change except underflow is set; a same-cycle push is still accepted, so count becomes 1.
REQ-022 Simultaneous accepted push and pop: count unchanged, both pointers advance; valid in all states, including full.
REQ-023 sample_out is combinational from storage[rd_ptr] when count>0 and is forced to 0 when empty; latency from push to visibility is 1 cycle.
REQ-024 Status outputs (full, empty, sample_valid, level_irq) are combinational from the count register.
REQ-025 flush=1: pointers and count go to 0 on the next edge; same-cycle push and pop are ignored and raise no flags; the sticky flags are unaffected.
REQ-026 clear_flags=1 clears overflow and underflow; if a new overflow or underflow event occurs in the same cycle, that flag ends up set (set wins).
REQ-027 Storage contents are not reset; because of REQ-023, no stale data is ever visible.

Reset
REQ-028 reset=0 immediately forces pointers=0, count=0, overflow=0, underflow=0, sample_out=0, sample_valid=0, empty=1, full=0 and level_irq=0, independent of clock.
REQ-029 Reset deassertion is synchronized internally (two-flop release); the first push is accepted no earlier than the 2nd rising edge after reset goes high.
REQ-030 Reset asserted mid-operation discards all contents; no partial push or pop completes.

Verification
REQ-031 Reset release, then push 0x11,0x22,0x33 on consecutive cycles -> count=3; sample_out=0x11; after one pop sample_out=0x22 and count=2.
REQ-032 DEPTH=8: push 9 samples with no pops -> full=1, count=8, overflow=1; 8 pops return samples 1..8 in order; the 9th sample is never seen.
REQ-033 Full FIFO, push 0xAA and pop in the same cycle -> count stays 8, overflow=0; 0xAA exits 8th.
REQ-034 Empty FIFO, pop and push 0x5 in the same cycle -> underflow=1, count=1, sample_out=0x5; a following clear_flags -> underflow=0.
REQ-035 threshold=4: push 3 -> level_irq=0; push 4th -> level_irq=1; flush -> count=0, level_irq=0, flags retained.
REQ-036 Assert reset at count=5 mid-stream -> all outputs take reset values asynchronously; the next push after release gives count=1.
